fwd_scoreboard_unit: RTL

//  Parametrised successor to the dual-pipe execute hazard detector. Sits between decode and execute
//  and resolves read-after-write (RAW) hazards for a LANES-wide in-order bundle.

---
 rtl/fwd_scoreboard_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard_unit.sv
// Operand-forwarding and RAW-hazard unit for a LANES-wide in-order bundle.
// It forwards from EXE, a one-deep writeback history and returning loads, and tracks outstanding loads.
module fwd_scoreboard_unit #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 40,
  parameter int ADDR_W      = 5,
  parameter int UNUSED_ADDR = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ext_stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          dec_valid,
  input  logic [LANES*ADDR_W-1:0]   dec_addr_rm,
  input  logic [LANES*ADDR_W-1:0]   dec_addr_rn,
  input  logic [LANES-1:0]          dec_wr_en,
  input  logic [LANES*ADDR_W-1:0]   dec_addr_rd,
  input  logic [LANES*DATA_W-1:0]   dec_rm_in,
  input  logic [LANES*DATA_W-1:0]   dec_rn_in,
  input  logic [LANES-1:0]          exe_valid,
  input  logic [LANES-1:0]          exe_wr_en,
  input  logic [LANES-1:0]          exe_is_load,
  input  logic [LANES*ADDR_W-1:0]   exe_addr_rd,
  input  logic [LANES*DATA_W-1:0]   exe_data,
  input  logic                      ld_ret_valid,
  input  logic [ADDR_W-1:0]         ld_ret_addr,
  input  logic [DATA_W-1:0]         ld_ret_data,
  output logic [LANES-1:0]          stall,
  output logic [LANES*DATA_W-1:0]   rm_out,
  output logic [LANES*DATA_W-1:0]   rn_out,
  output logic [2**ADDR_W-1:0]      sb_pending,
  output logic                      sb_err
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] UNUSED = ADDR_W'(UNUSED_ADDR);

  logic [LANES-1:0]        hist_valid;
  logic [LANES*ADDR_W-1:0] hist_addr;
  logic [LANES*DATA_W-1:0] hist_data;
  logic [NREG-1:0]         sb;
  logic [NREG-1:0]         sb_nxt;
  logic [LANES-1:0]        raw;
  logic                    ld_fwd;

  assign ld_fwd     = ld_ret_valid && sb[ld_ret_addr];
  assign sb_pending = sb;

  // Sources are resolved lowest priority first so higher-priority hits overwrite val.
  always_comb begin : resolve
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              used;
    logic              hit_exe;
    logic              hit_hist;
    logic              ld_block;
    logic              pend;
    logic              intra;
    int                lane;
    raw    = '0;
    rm_out = dec_rm_in;
    rn_out = dec_rn_in;
    addr = '0; val = '0; used = 1'b0; hit_exe = 1'b0; hit_hist = 1'b0;
    ld_block = 1'b0; pend = 1'b0; intra = 1'b0; lane = 0;
    for (int s = 0; s < 2*LANES; s++) begin
      lane = s / 2;
      if (s % 2 == 0) begin
        addr = dec_addr_rm[lane*ADDR_W +: ADDR_W];
        val  = dec_rm_in[lane*DATA_W +: DATA_W];
      end else begin
        addr = dec_addr_rn[lane*ADDR_W +: ADDR_W];
        val  = dec_rn_in[lane*DATA_W +: DATA_W];
      end
      used     = (addr != UNUSED);
      hit_exe  = 1'b0;
      hit_hist = 1'b0;
      ld_block = 1'b0;
      intra    = 1'b0;
      for (int h = 0; h < LANES; h++) begin
        if (used && hist_valid[h] && hist_addr[h*ADDR_W +: ADDR_W] == addr) begin
          val      = hist_data[h*DATA_W +: DATA_W];
          hit_hist = 1'b1;
        end
      end
      if (used && ld_fwd && ld_ret_addr == addr) val = ld_ret_data;
      // The youngest matching EXE lane decides whether the source is blocked by a load.
      for (int e = 0; e < LANES; e++) begin
        if (used && exe_valid[e] && exe_wr_en[e] && exe_addr_rd[e*ADDR_W +: ADDR_W] == addr) begin
          hit_exe  = 1'b1;
          ld_block = exe_is_load[e];
          if (!exe_is_load[e]) val = exe_data[e*DATA_W +: DATA_W];
        end
      end
      pend = used && sb[addr] && !(ld_ret_valid && ld_ret_addr == addr) && !hit_exe && !hit_hist;
      for (int j = 0; j < LANES; j++) begin
        if (j < lane && used && dec_wr_en[j] && dec_addr_rd[j*ADDR_W +: ADDR_W] == addr) intra = 1'b1;
      end
      if (dec_valid[lane] && (ld_block || pend || intra)) raw[lane] = 1'b1;
      if (s % 2 == 0) rm_out[lane*DATA_W +: DATA_W] = val;
      else            rn_out[lane*DATA_W +: DATA_W] = val;
    end
    if (rst) begin
      rm_out = dec_rm_in;
      rn_out = dec_rn_in;
    end
  end

  // A stalled lane holds every younger lane behind it.
  always_comb begin : stall_chain
    logic acc;
    acc   = 1'b0;
    stall = '0;
    for (int k = 0; k < LANES; k++) begin
      acc      = acc | raw[k];
      stall[k] = acc && !rst;
    end
  end

  always_comb begin
    sb_nxt = sb;
    if (ld_ret_valid) sb_nxt[ld_ret_addr] = 1'b0;
    if (!ext_stall) begin
      for (int e = 0; e < LANES; e++) begin
        if (exe_valid[e] && exe_wr_en[e] && exe_is_load[e] && exe_addr_rd[e*ADDR_W +: ADDR_W] != UNUSED)
          sb_nxt[exe_addr_rd[e*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= '0;
      hist_addr  <= '0;
      hist_data  <= '0;
      sb         <= '0;
      sb_err     <= 1'b0;
    end else begin
      sb <= sb_nxt;
      if (ld_ret_valid && !sb[ld_ret_addr]) sb_err <= 1'b1;
      if (!ext_stall) begin
        hist_valid <= flush ? '0 : (exe_valid & exe_wr_en & ~exe_is_load);
        hist_addr  <= exe_addr_rd;
        hist_data  <= exe_data;
      end
    end
  end
endmodule
